// File: rtl/tpu_tile_sequencer.sv
// Tile sequencer for an N x N systolic array: accepts one matmul instruction,
// then walks the (n-tile, k-tile) grid, loading weights, waiting for activations
// and computing. It drives the accumulator with skewed addresses and column masks.
// All outputs decode from registered state only.
module tpu_tile_sequencer #(
    parameter int N          = 32,
    parameter int DIM_W      = 9,
    parameter int TILE_W     = 4,
    parameter int ACC_ADDR_W = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  logic [DIM_W-1:0]      instr_h_dim_i,
    input  logic [TILE_W-1:0]     instr_k_tiles_i,
    input  logic [TILE_W-1:0]     instr_n_tiles_i,
    input  logic [ACC_ADDR_W-1:0] instr_acc_base_i,
    input  logic                  instr_accumulate_i,
    input  logic                  weight_fifo_valid_i,
    input  logic                  activations_rdy_i,
    output logic                  load_weights_o,
    output logic                  load_activations_o,
    output logic                  stall_compute_o,
    output logic                  mac_compute_o,
    output logic                  write_accumulator_o,
    output logic                  read_accumulator_o,
    output logic                  accumulator_add_o,
    output logic [ACC_ADDR_W-1:0] accumulator_addr_wr_o,
    output logic [ACC_ADDR_W-1:0] accumulator_addr_rd_o,
    output logic [N-1:0]          accum_addr_mask_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int LW = $clog2(N);
    // Stride and row count need one bit beyond the row field.
    localparam int SW = DIM_W + 1;
    // Compute counter covers N fill cycles plus a full stride of drain cycles.
    localparam int CW = DIM_W + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_COMP = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [LW-1:0]         wcnt_q, wcnt_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TILE_W-1:0]     k_idx_q, k_idx_d;
    logic [TILE_W-1:0]     n_idx_q, n_idx_d;
    logic                  done_q, done_d;
    logic [TILE_W-1:0]     k_tiles_q, k_tiles_d;
    logic [TILE_W-1:0]     n_tiles_q, n_tiles_d;
    logic [ACC_ADDR_W-1:0] tile_base_q, tile_base_d;
    logic [SW-1:0]         stride_q, stride_d;
    logic [SW-1:0]         rows_q, rows_d;
    logic                  accumulate_q, accumulate_d;

    logic                  drain;
    logic                  last_drain;
    logic [CW-1:0]         w;
    logic [N-1:0]          mask;

    assign drain      = (state_q == S_COMP) && (cnt_q >= CW'(N));
    assign w          = cnt_q - CW'(N);
    assign last_drain = (state_q == S_COMP) &&
                        (cnt_q == (CW'(N) + CW'(stride_q) - CW'(1)));

    // Next-state logic: handshake, weight-row counting, compute counting, tile advance.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        cnt_d        = cnt_q;
        k_idx_d      = k_idx_q;
        n_idx_d      = n_idx_q;
        done_d       = 1'b0;
        k_tiles_d    = k_tiles_q;
        n_tiles_d    = n_tiles_q;
        tile_base_d  = tile_base_q;
        stride_d     = stride_q;
        rows_d       = rows_q;
        accumulate_d = accumulate_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid_i) begin
                    k_tiles_d    = instr_k_tiles_i;
                    n_tiles_d    = instr_n_tiles_i;
                    tile_base_d  = instr_acc_base_i;
                    accumulate_d = instr_accumulate_i;
                    rows_d       = SW'(instr_h_dim_i) + SW'(1);
                    // R + N - 1 with R = h_dim + 1
                    stride_d     = SW'(instr_h_dim_i) + SW'(N);
                    k_idx_d      = '0;
                    n_idx_d      = '0;
                    wcnt_d       = '0;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                if (weight_fifo_valid_i) begin
                    if (wcnt_q == LW'(N - 1)) begin
                        wcnt_d  = '0;
                        state_d = S_WAIT;
                    end else begin
                        wcnt_d = wcnt_q + LW'(1);
                    end
                end
            end
            S_WAIT: begin
                if (activations_rdy_i) begin
                    cnt_d   = '0;
                    state_d = S_COMP;
                end
            end
            default: begin
                if (last_drain) begin
                    cnt_d = '0;
                    if (k_idx_q < k_tiles_q) begin
                        k_idx_d = k_idx_q + TILE_W'(1);
                        state_d = S_LOAD;
                    end else if (n_idx_q < n_tiles_q) begin
                        k_idx_d     = '0;
                        n_idx_d     = n_idx_q + TILE_W'(1);
                        // Running base: each n-tile occupies exactly one stride of entries.
                        tile_base_d = tile_base_q + ACC_ADDR_W'(stride_q);
                        state_d     = S_LOAD;
                    end else begin
                        k_idx_d = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // Diagonal column mask: column j writes while its R outputs drain, delayed j cycles by the skew.
    always_comb begin
        mask = '0;
        if (drain) begin
            for (int j = 0; j < N; j++) begin
                if ((w >= CW'(j)) && ((w - CW'(j)) < CW'(rows_q))) begin
                    mask[N-1-j] = 1'b1;
                end
            end
        end
    end

    // Moore output decode from state and counters.
    always_comb begin
        instr_ready_o         = (state_q == S_IDLE);
        busy_o                = (state_q != S_IDLE);
        done_o                = done_q;
        load_weights_o        = (state_q == S_LOAD);
        load_activations_o    = (state_q == S_WAIT) || (state_q == S_COMP);
        mac_compute_o         = (state_q == S_COMP);
        stall_compute_o       = (state_q != S_COMP);
        write_accumulator_o   = 1'b0;
        read_accumulator_o    = 1'b0;
        accumulator_add_o     = 1'b0;
        accumulator_addr_wr_o = '0;
        accumulator_addr_rd_o = '0;
        accum_addr_mask_o     = mask;
        if (drain) begin
            write_accumulator_o   = 1'b1;
            read_accumulator_o    = (k_idx_q != '0) || accumulate_q;
            accumulator_add_o     = (k_idx_q != '0) || accumulate_q;
            accumulator_addr_wr_o = tile_base_q + ACC_ADDR_W'(w);
            // Read runs one entry ahead so the sum is ready when the write lands.
            accumulator_addr_rd_o = tile_base_q + ACC_ADDR_W'(w) + ACC_ADDR_W'(1);
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            cnt_q   <= '0;
            k_idx_q <= '0;
            n_idx_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            cnt_q   <= cnt_d;
            k_idx_q <= k_idx_d;
            n_idx_q <= n_idx_d;
            done_q  <= done_d;
        end
    end

    // Latched instruction fields and tile base; only observed while busy, so no reset.
    always_ff @(posedge clk_i) begin
        k_tiles_q    <= k_tiles_d;
        n_tiles_q    <= n_tiles_d;
        tile_base_q  <= tile_base_d;
        stride_q     <= stride_d;
        rows_q       <= rows_d;
        accumulate_q <= accumulate_d;
    end

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Directed bench for tpu_tile_sequencer at N=8 with hand-computed expectations.
module tb_tpu_tile_sequencer;

    localparam int N      = 8;
    localparam int DIM_W  = 9;
    localparam int TILE_W = 4;
    localparam int AW     = 7;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              instr_valid_i;
    logic              instr_ready_o;
    logic [DIM_W-1:0]  instr_h_dim_i;
    logic [TILE_W-1:0] instr_k_tiles_i;
    logic [TILE_W-1:0] instr_n_tiles_i;
    logic [AW-1:0]     instr_acc_base_i;
    logic              instr_accumulate_i;
    logic              weight_fifo_valid_i;
    logic              activations_rdy_i;
    logic              load_weights_o;
    logic              load_activations_o;
    logic              stall_compute_o;
    logic              mac_compute_o;
    logic              write_accumulator_o;
    logic              read_accumulator_o;
    logic              accumulator_add_o;
    logic [AW-1:0]     accumulator_addr_wr_o;
    logic [AW-1:0]     accumulator_addr_rd_o;
    logic [N-1:0]      accum_addr_mask_o;
    logic              busy_o;
    logic              done_o;

    tpu_tile_sequencer #(
        .N(N), .DIM_W(DIM_W), .TILE_W(TILE_W), .ACC_ADDR_W(AW)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_ni),
        .instr_valid_i        (instr_valid_i),
        .instr_ready_o        (instr_ready_o),
        .instr_h_dim_i        (instr_h_dim_i),
        .instr_k_tiles_i      (instr_k_tiles_i),
        .instr_n_tiles_i      (instr_n_tiles_i),
        .instr_acc_base_i     (instr_acc_base_i),
        .instr_accumulate_i   (instr_accumulate_i),
        .weight_fifo_valid_i  (weight_fifo_valid_i),
        .activations_rdy_i    (activations_rdy_i),
        .load_weights_o       (load_weights_o),
        .load_activations_o   (load_activations_o),
        .stall_compute_o      (stall_compute_o),
        .mac_compute_o        (mac_compute_o),
        .write_accumulator_o  (write_accumulator_o),
        .read_accumulator_o   (read_accumulator_o),
        .accumulator_add_o    (accumulator_add_o),
        .accumulator_addr_wr_o(accumulator_addr_wr_o),
        .accumulator_addr_rd_o(accumulator_addr_rd_o),
        .accum_addr_mask_o    (accum_addr_mask_o),
        .busy_o               (busy_o),
        .done_o               (done_o)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    string tname    = "reset";

    int cfg_alt = 0, cfg_delay = 0, cfg_pulse = 0;
    int load_cyc, phase_lc, wait_cyc, phase_wc, fill_cyc, done_cnt, viol, ff_masks;
    int pulse_seen, pulse_accept;
    logic [AW-1:0] wr_q[$];
    logic [AW-1:0] rd_q[$];
    logic [N-1:0]  mk_q[$];
    logic          rden_q[$];
    logic          add_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", tname, tag, got, exp);
        end
    endtask

    function automatic int count_rd(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi && i < rden_q.size(); i++) c += int'(rden_q[i]);
        return c;
    endfunction

    function automatic int count_add(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi && i < add_q.size(); i++) c += int'(add_q[i]);
        return c;
    endfunction

    // Write addresses must run contiguously from base, wrapping at 128.
    function automatic int seq_err(input int base);
        int e = 0;
        for (int i = 0; i < wr_q.size(); i++) if (int'(wr_q[i]) != ((base + i) % 128)) e++;
        return e;
    endfunction

    function automatic int rd_ahead_err(input int lo, input int hi);
        int e = 0;
        for (int i = lo; i <= hi && i < wr_q.size(); i++)
            if (int'(rd_q[i]) != ((int'(wr_q[i]) + 1) % 128)) e++;
        return e;
    endfunction

    // One clock: sample outputs #1 after the edge, then drive inputs for the next edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (load_weights_o) begin load_cyc++; phase_lc++; end else phase_lc = 0;
        if (load_activations_o && !mac_compute_o) begin wait_cyc++; phase_wc++; end else phase_wc = 0;
        if (mac_compute_o && !write_accumulator_o) fill_cyc++;
        if (write_accumulator_o) begin
            wr_q.push_back(accumulator_addr_wr_o);
            rd_q.push_back(accumulator_addr_rd_o);
            mk_q.push_back(accum_addr_mask_o);
            rden_q.push_back(read_accumulator_o);
            add_q.push_back(accumulator_add_o);
            if (accum_addr_mask_o == '1) ff_masks++;
        end else if (accum_addr_mask_o != '0 || accumulator_addr_wr_o != '0 ||
                     accumulator_addr_rd_o != '0 || read_accumulator_o || accumulator_add_o) begin
            viol++;
        end
        if (mac_compute_o == stall_compute_o) viol++;
        if (done_o) done_cnt++;
        weight_fifo_valid_i = (load_weights_o && cfg_alt != 0) ? (phase_lc % 2 == 0) : 1'b1;
        activations_rdy_i   = (load_activations_o && !mac_compute_o) ? (phase_wc > cfg_delay) : 1'b1;
        instr_valid_i       = (cfg_pulse != 0) && mac_compute_o && (fill_cyc == 3);
        if (instr_valid_i) begin
            pulse_seen++;
            if (instr_ready_o) pulse_accept++;
        end
    endtask

    task automatic issue(input int h, input int k, input int n, input int base, input int acc);
        check_eq("ready_idle", 64'(instr_ready_o), 64'(1));
        instr_h_dim_i      = DIM_W'(h);
        instr_k_tiles_i    = TILE_W'(k);
        instr_n_tiles_i    = TILE_W'(n);
        instr_acc_base_i   = AW'(base);
        instr_accumulate_i = acc[0];
        instr_valid_i      = 1'b1;
        load_cyc = 0; phase_lc = 0; wait_cyc = 0; phase_wc = 0; fill_cyc = 0;
        done_cnt = 0; viol = 0; ff_masks = 0; pulse_seen = 0; pulse_accept = 0;
        wr_q.delete(); rd_q.delete(); mk_q.delete(); rden_q.delete(); add_q.delete();
        step();
        check_eq("busy_after_hs", 64'(busy_o), 64'(1));
        check_eq("ready_after_hs", 64'(instr_ready_o), 64'(0));
        check_eq("load_after_hs", 64'(load_weights_o), 64'(1));
        check_eq("done_low_after_hs", 64'(done_o), 64'(0));
    endtask

    task automatic run_to_done(input int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (done_o) seen = 1'b1;
        end
        check_eq("done_seen", 64'(seen), 64'(1));
        check_eq("ready_at_done", 64'(instr_ready_o), 64'(1));
        check_eq("busy_at_done", 64'(busy_o), 64'(0));
        check_eq("done_count", 64'(done_cnt), 64'(1));
        check_eq("idle_outputs_quiet", 64'(viol), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni              = 1'b0;
        instr_valid_i       = 1'b0;
        instr_h_dim_i       = '0;
        instr_k_tiles_i     = '0;
        instr_n_tiles_i     = '0;
        instr_acc_base_i    = '0;
        instr_accumulate_i  = 1'b0;
        weight_fifo_valid_i = 1'b1;
        activations_rdy_i   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("ready", 64'(instr_ready_o), 64'(1));
        check_eq("stall", 64'(stall_compute_o), 64'(1));
        check_eq("busy", 64'(busy_o), 64'(0));
        check_eq("done", 64'(done_o), 64'(0));
        check_eq("load_w", 64'(load_weights_o), 64'(0));
        check_eq("mac", 64'(mac_compute_o), 64'(0));
        check_eq("write", 64'(write_accumulator_o), 64'(0));
        check_eq("mask", 64'(accum_addr_mask_o), 64'(0));
        rst_ni = 1'b1;
        step();

        // Single tile, R=16: stride 23
        tname = "t1_single";
        issue(15, 0, 0, 0, 0);
        run_to_done(200);
        check_eq("load_cycles", 64'(load_cyc), 64'(8));
        check_eq("wait_cycles", 64'(wait_cyc), 64'(1));
        check_eq("fill_cycles", 64'(fill_cyc), 64'(8));
        check_eq("writes", 64'(wr_q.size()), 64'(23));
        check_eq("addr_w0", 64'(wr_q[0]), 64'(0));
        check_eq("addr_w22", 64'(wr_q[22]), 64'(22));
        check_eq("addr_seq", 64'(seq_err(0)), 64'(0));
        check_eq("mask_w0", 64'(mk_q[0]), 64'h80);
        check_eq("mask_w6", 64'(mk_q[6]), 64'hFE);
        check_eq("mask_w7", 64'(mk_q[7]), 64'hFF);
        check_eq("mask_w15", 64'(mk_q[15]), 64'hFF);
        check_eq("mask_w16", 64'(mk_q[16]), 64'h7F);
        check_eq("mask_w22", 64'(mk_q[22]), 64'h01);
        check_eq("ff_count", 64'(ff_masks), 64'(9));
        check_eq("read_count", 64'(count_rd(0, 22)), 64'(0));
        check_eq("add_count", 64'(count_add(0, 22)), 64'(0));

        // Back-to-back from the done cycle; two k-tiles share addresses
        tname = "t2_k2";
        issue(15, 1, 0, 0, 0);
        run_to_done(300);
        check_eq("load_cycles", 64'(load_cyc), 64'(16));
        check_eq("writes", 64'(wr_q.size()), 64'(46));
        check_eq("tile1_w0", 64'(wr_q[23]), 64'(0));
        check_eq("tile1_w22", 64'(wr_q[45]), 64'(22));
        check_eq("tile0_read", 64'(count_rd(0, 22)), 64'(0));
        check_eq("tile1_read", 64'(count_rd(23, 45)), 64'(23));
        check_eq("tile1_add", 64'(count_add(23, 45)), 64'(23));
        check_eq("tile1_rd_w0", 64'(rd_q[23]), 64'(1));
        check_eq("tile1_rd_ahead", 64'(rd_ahead_err(23, 45)), 64'(0));

        // Three n-tiles from base 100: bases 100, 123, 18 with wrap inside tile 2
        tname = "t3_wrap";
        issue(15, 0, 2, 100, 0);
        run_to_done(400);
        check_eq("writes", 64'(wr_q.size()), 64'(69));
        check_eq("base0", 64'(wr_q[0]), 64'(100));
        check_eq("base1", 64'(wr_q[23]), 64'(123));
        check_eq("base2", 64'(wr_q[46]), 64'(18));
        check_eq("wr_127", 64'(wr_q[27]), 64'(127));
        check_eq("wr_wrap0", 64'(wr_q[28]), 64'(0));
        check_eq("rd_wrap0", 64'(rd_q[27]), 64'(0));
        check_eq("last_wr", 64'(wr_q[68]), 64'(40));
        check_eq("addr_seq", 64'(seq_err(100)), 64'(0));
        check_eq("read_count", 64'(count_rd(0, 68)), 64'(0));

        // R=3 < N: stride 10, never a full mask
        tname = "t4_short";
        issue(2, 0, 0, 0, 0);
        run_to_done(200);
        check_eq("fill_cycles", 64'(fill_cyc), 64'(8));
        check_eq("writes", 64'(wr_q.size()), 64'(10));
        check_eq("mask_w0", 64'(mk_q[0]), 64'h80);
        check_eq("mask_w2", 64'(mk_q[2]), 64'hE0);
        check_eq("mask_w5", 64'(mk_q[5]), 64'h1C);
        check_eq("mask_w9", 64'(mk_q[9]), 64'h01);
        check_eq("ff_count", 64'(ff_masks), 64'(0));

        // Sparse weight FIFO, late activations, accumulate mode, stray instr_valid
        tname = "t5_slow";
        cfg_alt = 1; cfg_delay = 5; cfg_pulse = 1;
        issue(15, 0, 0, 5, 1);
        run_to_done(300);
        check_eq("load_cycles", 64'(load_cyc), 64'(16));
        check_eq("wait_cycles", 64'(wait_cyc), 64'(6));
        check_eq("writes", 64'(wr_q.size()), 64'(23));
        check_eq("base", 64'(wr_q[0]), 64'(5));
        check_eq("rd_w0", 64'(rd_q[0]), 64'(6));
        check_eq("acc_read", 64'(count_rd(0, 22)), 64'(23));
        check_eq("acc_add", 64'(count_add(0, 22)), 64'(23));
        check_eq("pulse_seen", 64'(pulse_seen), 64'(1));
        check_eq("pulse_accepted", 64'(pulse_accept), 64'(0));
        cfg_alt = 0; cfg_delay = 0; cfg_pulse = 0;

        // Reset during drain at w=4 aborts the instruction
        tname = "t6_abort";
        issue(15, 0, 0, 0, 0);
        for (int i = 0; i < 200 && wr_q.size() < 5; i++) step();
        check_eq("reached_w4", 64'(wr_q.size()), 64'(5));
        check_eq("w4_addr", 64'(wr_q[4]), 64'(4));
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        check_eq("ready", 64'(instr_ready_o), 64'(1));
        check_eq("busy", 64'(busy_o), 64'(0));
        check_eq("done", 64'(done_o), 64'(0));
        check_eq("write", 64'(write_accumulator_o), 64'(0));
        check_eq("mac", 64'(mac_compute_o), 64'(0));
        check_eq("stall", 64'(stall_compute_o), 64'(1));
        check_eq("load_act", 64'(load_activations_o), 64'(0));
        check_eq("mask", 64'(accum_addr_mask_o), 64'(0));
        check_eq("wr_addr", 64'(accumulator_addr_wr_o), 64'(0));
        check_eq("no_more_writes", 64'(wr_q.size()), 64'(5));
        check_eq("no_done", 64'(done_cnt), 64'(0));
        tname = "t7_after_abort";
        issue(15, 0, 0, 0, 0);
        run_to_done(200);
        check_eq("writes", 64'(wr_q.size()), 64'(23));
        check_eq("addr_seq", 64'(seq_err(0)), 64'(0));
        step();
        check_eq("done_pulse_ends", 64'(done_o), 64'(0));
        check_eq("stays_idle", 64'(busy_o), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
